// File: rtl/forward_source_stage.sv
// Pipeline stage register that also publishes a forwarding source (valid/reg/value).
// Optional stall counter output enabled by defining FWD_STAGE_STALL_COUNT_EN.
module forward_source_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic [4:0]  inDestReg,
   input  logic [1:0]  inTNew,
   input  logic [31:0] inValue,
   input  logic [31:0] inPC,
   input  logic [31:0] stageResult,
   output logic [4:0]  outDestReg,
   output logic [1:0]  outTNew,
   output logic [31:0] outValue,
   output logic [31:0] outPC,
   output logic        srcValid,
   output logic [4:0]  srcReg,
   output logic [31:0] srcValue
`ifdef FWD_STAGE_STALL_COUNT_EN
   ,
   output logic [31:0] stallCount
`endif
);

   logic [4:0]  dest_reg;
   logic [1:0]  t_new;
   logic [31:0] value;
   logic [31:0] pc;
   logic        ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         dest_reg <= '0;
         t_new    <= '0;
         value    <= '0;
         pc       <= '0;
         ready    <= 1'b1;
      end else if (stall) begin
         // Held instruction whose result is due now latches it once, so later
         // changes of stageResult cannot disturb the forwarded value.
         if (t_new == 2'd0 && !ready) begin
            value <= stageResult;
            ready <= 1'b1;
         end
      end else if (flush) begin
         dest_reg <= '0;
         t_new    <= '0;
         value    <= '0;
         pc       <= '0;
         ready    <= 1'b1;
      end else begin
         dest_reg <= inDestReg;
         pc       <= inPC;
         if (inTNew == 2'd0) begin
            t_new <= '0;
            value <= inValue;
            ready <= 1'b1;
         end else begin
            t_new <= inTNew - 2'd1;
            value <= '0;
            ready <= 1'b0;
         end
      end
   end

`ifdef FWD_STAGE_STALL_COUNT_EN
   always_ff @(posedge clk) begin
      if (reset)
         stallCount <= '0;
      else if (stall && dest_reg != 5'd0 && stallCount != '1)
         stallCount <= stallCount + 32'd1;
   end
`endif

   always_comb begin
      srcReg     = dest_reg;
      srcValid   = (t_new == 2'd0);
      srcValue   = ready ? value : stageResult;
      outDestReg = dest_reg;
      outTNew    = t_new;
      outValue   = srcValue;
      outPC      = pc;
   end

endmodule

// File: tb/tb_forward_source_stage.sv
// Self-checking bench: directed vector table, then randomized cycles against a reference model.
// Also exercises stallCount when FWD_STAGE_STALL_COUNT_EN is defined.
module tb_forward_source_stage;

   logic        clk = 1'b0;
   logic        reset, stall, flush;
   logic [4:0]  inDestReg;
   logic [1:0]  inTNew;
   logic [31:0] inValue, inPC, stageResult;
   logic [4:0]  outDestReg, srcReg;
   logic [1:0]  outTNew;
   logic [31:0] outValue, outPC, srcValue;
   logic        srcValid;
`ifdef FWD_STAGE_STALL_COUNT_EN
   logic [31:0] stallCount;
`endif

   int unsigned checks = 0;
   int unsigned failures = 0;

   forward_source_stage dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .inDestReg(inDestReg), .inTNew(inTNew), .inValue(inValue), .inPC(inPC),
      .stageResult(stageResult),
      .outDestReg(outDestReg), .outTNew(outTNew), .outValue(outValue), .outPC(outPC),
      .srcValid(srcValid), .srcReg(srcReg), .srcValue(srcValue)
`ifdef FWD_STAGE_STALL_COUNT_EN
      , .stallCount(stallCount)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic        rst, stl, fl;
      logic [4:0]  dest;
      logic [1:0]  tn;
      logic [31:0] val, pc, sr;
      logic        e_valid;
      logic [4:0]  e_reg;
      logic [31:0] e_value;
      logic [1:0]  e_tnew;
      logic [31:0] e_pc;
   } vec_t;

   vec_t vecs[15];

   // Reference model: the instruction occupying the stage and what is known of its result.
   int unsigned m_dest, m_wait, m_pc, m_result, m_count;
   bit          m_known;

   task automatic model_bubble();
      m_dest = 0; m_wait = 0; m_pc = 0; m_result = 0; m_known = 1;
   endtask

   task automatic model_edge(input bit r, input bit s, input bit f, input int unsigned d,
                             input int unsigned t, input int unsigned v, input int unsigned p,
                             input int unsigned sr);
      if (r) begin
         model_bubble();
         m_count = 0;
      end else begin
         if (s && m_dest != 0 && m_count != 32'hFFFF_FFFF) m_count++;
         if (s) begin
            if (m_wait == 0 && !m_known) begin
               m_result = sr; m_known = 1;
            end
         end else if (f) begin
            model_bubble();
         end else begin
            m_dest = d; m_pc = p;
            m_wait = (t > 0) ? t - 1 : 0;
            m_known = (t == 0);
            m_result = (t == 0) ? v : 0;
         end
      end
   endtask

   task automatic apply(input vec_t v);
      reset = v.rst; stall = v.stl; flush = v.fl;
      inDestReg = v.dest; inTNew = v.tn; inValue = v.val; inPC = v.pc; stageResult = v.sr;
   endtask

   function automatic vec_t mk(input logic r, s, f, input logic [4:0] d, input logic [1:0] t,
                               input logic [31:0] v, p, sr, input logic ev, input logic [4:0] er,
                               input logic [31:0] eval, input logic [1:0] et, input logic [31:0] ep);
      vec_t x;
      x.rst = r; x.stl = s; x.fl = f; x.dest = d; x.tn = t; x.val = v; x.pc = p; x.sr = sr;
      x.e_valid = ev; x.e_reg = er; x.e_value = eval; x.e_tnew = et; x.e_pc = ep;
      return x;
   endfunction

   initial begin
      //            rst s f dest tn val       pc      sr    | valid reg value tnew pc
      vecs[0]  = mk(1, 0, 0, 5'd0, 2'd0, 32'h0,    32'h0,   32'h11, 1, 0, 32'h0,    0, 32'h0);
      vecs[1]  = mk(0, 0, 0, 5'd5, 2'd0, 32'h1234, 32'h100, 32'h55, 1, 5, 32'h1234, 0, 32'h100);
      vecs[2]  = mk(0, 0, 0, 5'd8, 2'd1, 32'h77,   32'h104, 32'hAA, 1, 8, 32'hAA,   0, 32'h104);
      vecs[3]  = mk(0, 1, 0, 5'd1, 2'd0, 32'h1,    32'h1,   32'hAA, 1, 8, 32'hAA,   0, 32'h104);
      vecs[4]  = mk(0, 1, 0, 5'd1, 2'd0, 32'h1,    32'h1,   32'hBB, 1, 8, 32'hAA,   0, 32'h104);
      vecs[5]  = mk(0, 0, 0, 5'd3, 2'd2, 32'h33,   32'h108, 32'hCC, 0, 3, 32'hCC,   1, 32'h108);
      vecs[6]  = mk(0, 1, 0, 5'd2, 2'd0, 32'h2,    32'h2,   32'hCC, 0, 3, 32'hCC,   1, 32'h108);
      vecs[7]  = mk(0, 1, 0, 5'd2, 2'd0, 32'h2,    32'h2,   32'hCD, 0, 3, 32'hCD,   1, 32'h108);
      vecs[8]  = mk(0, 1, 1, 5'd2, 2'd0, 32'h2,    32'h2,   32'hCE, 0, 3, 32'hCE,   1, 32'h108);
      vecs[9]  = mk(0, 0, 0, 5'd7, 2'd0, 32'h700,  32'h10C, 32'hDD, 1, 7, 32'h700,  0, 32'h10C);
      vecs[10] = mk(0, 1, 1, 5'd4, 2'd0, 32'h4,    32'h4,   32'hDD, 1, 7, 32'h700,  0, 32'h10C);
      vecs[11] = mk(0, 0, 1, 5'd4, 2'd0, 32'h4,    32'h4,   32'hDD, 1, 0, 32'h0,    0, 32'h0);
      vecs[12] = mk(0, 0, 0, 5'd9, 2'd1, 32'h9,    32'h110, 32'h99, 1, 9, 32'h99,   0, 32'h110);
      vecs[13] = mk(1, 1, 0, 5'd6, 2'd0, 32'h6,    32'h6,   32'h99, 1, 0, 32'h0,    0, 32'h0);
      vecs[14] = mk(0, 0, 0, 5'd12, 2'd3, 32'hE,   32'h114, 32'hEE, 0, 12, 32'hEE,  2, 32'h114);

      apply(vecs[0]);
      @(negedge clk);
      for (int i = 0; i < 15; i++) begin
         apply(vecs[i]);
         @(posedge clk);
         @(negedge clk);
         #1;
         chk($sformatf("v%0d srcValid", i), {31'b0, srcValid}, {31'b0, vecs[i].e_valid});
         chk($sformatf("v%0d srcReg", i), {27'b0, srcReg}, {27'b0, vecs[i].e_reg});
         chk($sformatf("v%0d outDestReg", i), {27'b0, outDestReg}, {27'b0, vecs[i].e_reg});
         chk($sformatf("v%0d srcValue", i), srcValue, vecs[i].e_value);
         chk($sformatf("v%0d outValue", i), outValue, vecs[i].e_value);
         chk($sformatf("v%0d outTNew", i), {30'b0, outTNew}, {30'b0, vecs[i].e_tnew});
         chk($sformatf("v%0d outPC", i), outPC, vecs[i].e_pc);
`ifdef FWD_STAGE_STALL_COUNT_EN
         if (i == 13) chk("stallCount after reset", stallCount, 32'd0);
`endif
      end

      // Hold destReg=12 (tNew=2 -> 2) for three cycles: no decrement, counter counts each held edge.
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         @(negedge clk);
         #1;
         chk("hold tNew", {30'b0, outTNew}, 32'd2);
         chk("hold srcValid", {31'b0, srcValid}, 32'd0);
      end
`ifdef FWD_STAGE_STALL_COUNT_EN
      chk("stallCount after 3 holds", stallCount, 32'd3);
`endif

      // Randomized phase, starting from reset so the model and DUT agree.
      reset = 1'b1; stall = 1'b0; flush = 1'b0;
      @(posedge clk);
      model_bubble();
      m_count = 0;
      @(negedge clk);
      for (int c = 0; c < 400; c++) begin
         reset       = ($urandom_range(0, 39) == 0);
         stall       = ($urandom_range(0, 9) < 4);
         flush       = ($urandom_range(0, 9) < 2);
         inDestReg   = 5'($urandom_range(0, 31));
         inTNew      = 2'($urandom_range(0, 3));
         inValue     = $urandom;
         inPC        = $urandom;
         stageResult = $urandom;
         #1;
         chk("rnd srcValid", {31'b0, srcValid}, {31'b0, (m_wait == 0)});
         chk("rnd srcReg", {27'b0, srcReg}, m_dest);
         chk("rnd outDestReg", {27'b0, outDestReg}, m_dest);
         chk("rnd outTNew", {30'b0, outTNew}, m_wait);
         chk("rnd outPC", outPC, m_pc);
         chk("rnd srcValue", srcValue, m_known ? m_result : stageResult);
         chk("rnd outValue", outValue, m_known ? m_result : stageResult);
`ifdef FWD_STAGE_STALL_COUNT_EN
         chk("rnd stallCount", stallCount, m_count);
`endif
         @(posedge clk);
         model_edge(reset, stall, flush, inDestReg, inTNew, inValue, inPC, stageResult);
         @(negedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule

// File: doc/forward_source_stage.md
FORWARD_SOURCE_STAGE -- requirements
Module: forward_source_stage

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have: stall  in  1  hold stage contents this cycle.
REQ-004 SHALL have: flush  in  1  load bubble instead of inputs on advance.
REQ-005 SHALL have: inDestReg  in  5  destination register of incoming instruction (0 = none).
REQ-006 SHALL have: inTNew  in  2  cycles-until-result of incoming instruction, counted in stages.
REQ-007 SHALL have: inValue  in  32  incoming result, meaningful only when inTNew==0.
REQ-008 SHALL have: inPC  in  32  incoming PC, debug/trace only.
REQ-009 SHALL have: stageResult  in  32  result computed combinationally by this stage for the held instruction.
REQ-010 SHALL have: outDestReg  out  5, outTNew  out  2, outValue  out  32, outPC  out  32  next-stage payload.
REQ-011 SHALL have: srcValid  out  1, srcReg  out  5, srcValue  out  32  forwarding-source triple for operand forwarding controllers.
REQ-012 Clock and reset SHALL be named clk and reset; one clock; reset synchronous, active-high.

Function
REQ-013 State SHALL be: destReg[4:0], tNew[1:0], value[31:0], pc[31:0], ready (1 bit).
REQ-014 Advance cycle (stall=0, flush=0) SHALL load destReg=inDestReg, pc=inPC, tNew=(inTNew==0)?0:inTNew-1, ready=(inTNew==0), value=(inTNew==0)?inValue:0.
REQ-015 Advance cycle with flush=1 (stall=0) SHALL load bubble: destReg=0, tNew=0, value=0, pc=0, ready=1.
REQ-016 stall=1 SHALL take priority over flush; flush ignored while stall=1.
REQ-017 Hold cycle (stall=1) SHALL retain destReg, tNew, pc; tNew SHALL NOT decrement while held.
REQ-018 Hold cycle with tNew==0 and ready==0 SHALL capture value<=stageResult and set ready<=1.
REQ-019 Hold cycle with ready==1 or tNew!=0 SHALL retain value and ready.
REQ-020 srcReg SHALL equal destReg combinationally.
REQ-021 srcValid SHALL be 1 iff tNew==0 (bubbles report valid with destReg 0).
REQ-022 srcValue and outValue SHALL be value when ready==1, else stageResult (same-cycle, zero latency).
REQ-023 outDestReg, outTNew, outPC SHALL equal destReg, tNew, pc.
REQ-024 Latency input->outputs SHALL be exactly one advancing clock edge.
REQ-025 tNew arithmetic SHALL saturate at 0; inTNew==3 SHALL load tNew=2.

Reset
REQ-026 reset=1 at an edge SHALL force bubble state (destReg=0, tNew=0, value=0, pc=0, ready=1) regardless of stall/flush.
REQ-027 After reset: srcValid=1, srcReg=0, srcValue=0, outDestReg=0, outTNew=0, outValue=0, outPC=0.
REQ-028 Reset asserted mid-hold SHALL discard the held instruction; no stageResult capture that edge.

Configuration
REQ-029 Macro FWD_STAGE_STALL_COUNT_EN SHALL, when defined, add output stallCount  out  32.
REQ-030 With it: stallCount SHALL increment each edge where stall=1 and destReg!=0, saturate at 0xFFFFFFFF, reset to 0.
REQ-031 Without it: port and counter absent; all other behaviour identical.

Verification
REQ-032 Load inDestReg=5,inTNew=0,inValue=0x1234 -> next cycle srcValid=1,srcReg=5,srcValue=0x1234,outTNew=0.
REQ-033 Load inDestReg=8,inTNew=1, stageResult=0xAA, stall=1 two cycles, stageResult->0xBB in cycle 2 -> srcValid=1 both cycles, srcValue=0xAA then 0xAA (captured), outValue=0xAA.
REQ-034 Load inDestReg=3,inTNew=2, stall=1 three cycles -> srcValid=0, outTNew=1 throughout; release -> next stage payload outTNew=1.
REQ-035 stall=1 and flush=1 with held destReg=7 -> destReg stays 7; then stall=0,flush=1 -> srcReg=0,srcValid=1,srcValue=0.
REQ-036 reset=1 during hold of destReg=9,inTNew=1 -> next cycle all outputs 0, srcValid=1; with FWD_STAGE_STALL_COUNT_EN, stallCount=0 and counts 3 after three held cycles with destReg!=0.
